seq_pattern_gen: RTL
====================

SEQ_PATTERN_GEN -- requirements
Module: seq_pattern_gen

Interface
REQ-001 Parameter WIDTH, default 8: maximum pattern length in bits (legal range 2..16).
REQ-002 Parameter GAP_CYCLES, default 2: idle cycles inserted between repetitions (legal range 0..15).
REQ-003 Port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 Port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 Port start  input  1  request to begin a transmission; sampled only in IDLE.
REQ-006 Port pattern  input  WIDTH  bits to transmit; bit len-1 is sent first (MSB-first).
REQ-007 Port len  input  5  number of pattern bits to send per repetition.
REQ-008 Port reps  input  4  number of repetitions; value 0 is treated as 1.
REQ-009 Port abort  input  1  synchronous cancel of an active transmission.
REQ-010 Port x  output  1  serial bit stream; this stream feeds the team's sequence detectors.
REQ-011 Port x_valid  output  1  high when x carries a pattern bit.
REQ-012 Port busy  output  1  high from the cycle after an accepted start until done or abort.
REQ-013 Port done  output  1  one-cycle pulse after the last bit of the last repetition.
REQ-014 Port expect_y  output  1  golden flag: high with x when x is the third or later consecutive emitted 1.

Function
REQ-015 FSM states SHALL be IDLE, SEND, GAP and DONE, with encoding chosen freely.
REQ-016 IDLE -> SEND: on start=1 with 1<=len<=WIDTH, capture pattern, len and reps at that edge.
REQ-017 A start with len=0 or len>WIDTH SHALL be ignored; the block stays in IDLE with all outputs 0.
REQ-018 First bit latency: x=pattern[len-1] and x_valid=1 in the cycle after the accepting edge.
REQ-019 SEND SHALL emit exactly len bits on consecutive cycles, in order pattern[len-1] down to pattern[0].
REQ-020 SEND -> GAP after the last bit if repetitions remain and GAP_CYCLES>0; for GAP_CYCLES=0, SEND restarts at bit len-1 with no bubble.
REQ-021 GAP SHALL hold x=0 and x_valid=0 for exactly GAP_CYCLES cycles, then return to SEND.
REQ-022 SEND -> DONE after the last bit of the last repetition; no gap follows the final repetition.
REQ-023 DONE SHALL last one cycle with done=1, busy=0, x=0 and x_valid=0, then return to IDLE.
REQ-024 busy=1 in every SEND and GAP cycle; start while busy SHALL be ignored.
REQ-025 Changes on pattern, len or reps while busy SHALL have no effect; the captured copies are used.
REQ-026 abort=1 in SEND or GAP: at the next edge go to IDLE, all outputs 0, no done pulse.
REQ-027 abort in IDLE or DONE SHALL be ignored; if abort and start are both high in IDLE, abort wins and start is dropped.
REQ-028 Run counter: saturating at 3; increments on each emitted 1; cleared on an emitted 0, on any x_valid=0 cycle and on accept.
REQ-029 expect_y = x_valid & x & (run counter before this bit >= 2); this is combinational with x, and there is no extra latency.
REQ-030 Outside SEND, x, x_valid and expect_y SHALL all be 0.

Reset
REQ-031 rst_n=0 SHALL immediately force IDLE and x, x_valid, busy, done, expect_y=0, and clear the run counter and all captured registers.
REQ-032 Reset asserted mid-transmission SHALL abandon it without a done pulse; after release the block waits for a new start.

Verification
REQ-033 Basic transmission: WIDTH=8, start with pattern=8'b1011_0111, len=8, reps=1.
  - Expected x: 1,0,1,1,0,1,1,1 on cycles 1-8.
  - Expected expect_y: high only on cycle 8.
  - Expected done: high on cycle 9.
REQ-034 Repetitions with gap: pattern=3'b111, len=3, reps=2, GAP_CYCLES=2.
  - Expected x: 1,1,1,0,0,1,1,1, with x_valid low on cycles 4-5.
  - Expected expect_y: high on cycles 3 and 8.
  - Expected done: high on cycle 9.
REQ-035 Input handling:
  - Case A: a start pulse at cycle 3 of an active transmission, together with a change of pattern, SHALL leave the output stream unchanged.
  - Case B: start with len=0 SHALL be ignored, with busy staying 0.
REQ-036 Abort: abort during bit 4 of an 8-bit pattern.
  - Expected: outputs and busy are 0 on the next cycle, and done never pulses.
  - Expected: a new start is accepted the cycle after.
REQ-037 Mid-operation reset: pull rst_n low asynchronously mid-GAP.
  - Expected: all outputs 0 before the next edge.
  - Expected: after release, the block stays idle until start.
REQ-038 Loopback: drive x into the team's 3-ones detector with random patterns and reps.
  - Expected: the detector output equals expect_y on every valid cycle.

Source files
------------

// File: rtl/seq_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module   : seq_pattern_gen
// Purpose  : Serial pattern generator. Sends the low `len` bits of a captured
//            pattern MSB-first, repeats it `reps` times with GAP_CYCLES idle
//            cycles between repetitions, and raises a golden expect_y flag
//            whenever the emitted bit is the third or later consecutive 1.
// Ports    : clk      - clock, rising edge
//            rst_n    - asynchronous active-low reset
//            start    - begin a transmission (sampled only when idle)
//            pattern  - bits to send, bit len-1 goes out first
//            len      - bits per repetition (1..WIDTH accepted)
//            reps     - repetition count, 0 behaves as 1
//            abort    - cancel an active transmission
//            x        - serial bit stream
//            x_valid  - x carries a pattern bit
//            busy     - transmission in progress (SEND/GAP)
//            done     - one-cycle pulse after the final bit
//            expect_y - x is the third or later consecutive emitted 1
// Revision : 1.0 - initial release
// ============================================================================
module seq_pattern_gen #(
  parameter int WIDTH      = 8,
  parameter int GAP_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] pattern,
  input  logic [4:0]       len,
  input  logic [3:0]       reps,
  input  logic             abort,
  output logic             x,
  output logic             x_valid,
  output logic             busy,
  output logic             done,
  output logic             expect_y
);

  localparam int         c_IW       = $clog2(WIDTH);
  localparam logic [4:0] c_WIDTH    = 5'(WIDTH);
  localparam logic [3:0] c_GAP_LAST = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_GAP  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_pat;
  logic [c_IW-1:0]  r_len_m1;     // captured len-1: index of first bit
  logic [c_IW-1:0]  r_idx;        // index of the bit currently on x
  logic [3:0]       r_reps_left;  // repetitions still to start after this one
  logic [3:0]       r_gap_cnt;
  logic [1:0]       r_run;        // consecutive 1s up to and including current x
  logic             r_x;
  logic             r_x_valid;
  logic             r_busy;
  logic             r_done;
  logic             r_expect_y;

  logic             w_len_ok;
  logic [c_IW-1:0]  w_len_m1;
  logic [c_IW-1:0]  w_idx_dec;
  logic             w_bit_new;    // first bit taken straight from the port
  logic             w_bit_first;  // first bit of a repetition from the captured copy
  logic             w_bit_cont;   // bit that follows the current one without a bubble
  logic [1:0]       w_run_inc;

  always_comb begin
    w_len_ok    = (len != 5'd0) && (len <= c_WIDTH);
    w_len_m1    = c_IW'(len - 5'd1);
    w_idx_dec   = r_idx - c_IW'(1);
    w_bit_new   = pattern[w_len_m1];
    w_bit_first = r_pat[r_len_m1];
    // With no gap a new repetition wraps straight back to the first bit.
    w_bit_cont  = (r_idx != '0) ? r_pat[w_idx_dec] : w_bit_first;
    w_run_inc   = (r_run == 2'd3) ? 2'd3 : r_run + 2'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_pat       <= '0;
      r_len_m1    <= '0;
      r_idx       <= '0;
      r_reps_left <= '0;
      r_gap_cnt   <= '0;
      r_run       <= '0;
      r_x         <= 1'b0;
      r_x_valid   <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_expect_y  <= 1'b0;
    end else begin
      // Any cycle that does not emit a bit shows zeros and breaks the run.
      r_x        <= 1'b0;
      r_x_valid  <= 1'b0;
      r_expect_y <= 1'b0;
      r_done     <= 1'b0;
      r_run      <= 2'd0;
      unique case (r_state)
        S_IDLE: begin
          r_busy <= 1'b0;
          if (!abort && start && w_len_ok) begin
            r_state     <= S_SEND;
            r_busy      <= 1'b1;
            r_pat       <= pattern;
            r_len_m1    <= w_len_m1;
            r_idx       <= w_len_m1;
            r_reps_left <= (reps == 4'd0) ? 4'd0 : reps - 4'd1;
            r_x         <= w_bit_new;
            r_x_valid   <= 1'b1;
            r_run       <= {1'b0, w_bit_new};
          end
        end
        S_SEND: begin
          if (abort) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else if (r_idx != '0 || (r_reps_left != 4'd0 && GAP_CYCLES == 0)) begin
            if (r_idx == '0) begin
              r_reps_left <= r_reps_left - 4'd1;
              r_idx       <= r_len_m1;
            end else begin
              r_idx <= w_idx_dec;
            end
            // Contiguous bit: the run carries over from the current bit.
            r_x        <= w_bit_cont;
            r_x_valid  <= 1'b1;
            r_expect_y <= w_bit_cont & r_run[1];
            r_run      <= w_bit_cont ? w_run_inc : 2'd0;
          end else if (r_reps_left != 4'd0) begin
            r_reps_left <= r_reps_left - 4'd1;
            r_gap_cnt   <= c_GAP_LAST;
            r_state     <= S_GAP;
          end else begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        S_GAP: begin
          if (abort) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else if (r_gap_cnt != 4'd0) begin
            r_gap_cnt <= r_gap_cnt - 4'd1;
          end else begin
            // The gap cleared the run, so this first bit starts from zero.
            r_state   <= S_SEND;
            r_idx     <= r_len_m1;
            r_x       <= w_bit_first;
            r_x_valid <= 1'b1;
            r_run     <= {1'b0, w_bit_first};
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign x        = r_x;
  assign x_valid  = r_x_valid;
  assign busy     = r_busy;
  assign done     = r_done;
  assign expect_y = r_expect_y;

endmodule
`default_nettype wire
